// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin 4-to-1 stream multiplexer.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Encoding matches o_valid: EMPTY drives 0, FULL drives 1.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Pointer advance after a grant; SEL_W-bit addition wraps 3 back to 0.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] g);
        return g + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux_4to1_rr_if.sv
// Stream bundle between four sources, the merging mux and one sink.
interface mux_4to1_rr_if import mux_pkg::*; #(parameter int width = 2);

    // Valid/ready: a word moves on channel n when i_valid[n] & i_ready[n] are
    // both high at a rising edge; likewise at the output when o_valid & o_ready.
    // i_ready never depends on data, and a source may drop i_valid untransferred.
    logic [width-1:0]  i0;
    logic [width-1:0]  i1;
    logic [width-1:0]  i2;
    logic [width-1:0]  i3;
    logic [NUM_CH-1:0] i_valid;
    logic [NUM_CH-1:0] i_ready;
    logic [width-1:0]  o;
    logic [SEL_W-1:0]  o_sel;
    logic              o_valid;
    logic              o_ready;

    modport master (
        output i0, i1, i2, i3, i_valid, o_ready,
        input  i_ready, o, o_sel, o_valid
    );

    modport slave (
        input  i0, i1, i2, i3, i_valid, o_ready,
        output i_ready, o, o_sel, o_valid
    );

endinterface

// File: rtl/mux_4to1_rr_arb.sv
// Combinational round-robin arbiter: the first request at or above ptr (mod 4) wins.
module rr_arbiter_4 import mux_pkg::*; (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        if (en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = ptr + SEL_W'(k);
                if (!any && req[idx]) begin
                    any      = 1'b1;
                    gnt_idx  = idx;
                    gnt[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_4to1_rr.sv
// Registered 4-to-1 stream mux with round-robin arbitration; o_sel tags the
// source channel so it can drive a 1-to-4 demux directly.
module mux_4to1_rr import mux_pkg::*; #(parameter int width = 2) (
    input  logic             clk,
    input  logic             rst_n,
    mux_4to1_rr_if.slave     bus,
    output state_t           dbg_state,
    output logic [SEL_W-1:0] dbg_ptr
);

    state_t            state_q;
    state_t            next_state;
    logic [SEL_W-1:0]  ptr_q;
    logic [width-1:0]  o_q;
    logic [SEL_W-1:0]  sel_q;
    logic              ld;
    logic              arb_en;
    logic [NUM_CH-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              any;
    logic [width-1:0]  sel_data;

    // Load when empty or when the held word leaves this cycle; reset masks requests.
    assign ld     = (state_q == EMPTY) || bus.o_ready;
    assign arb_en = ld && rst_n;

    rr_arbiter_4 u_arb (
        .req     (bus.i_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        sel_data = bus.i0;
        case (gnt_idx)
            2'd0:    sel_data = bus.i0;
            2'd1:    sel_data = bus.i1;
            2'd2:    sel_data = bus.i2;
            default: sel_data = bus.i3;
        endcase
    end

    always_comb begin
        next_state = state_q;
        if (ld) begin
            next_state = any ? FULL : EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= next_state;
        end
    end

    // A grant only happens under ld, so a stalled word and the pointer stay put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q   <= '0;
            sel_q <= '0;
            ptr_q <= '0;
        end else if (any) begin
            o_q   <= sel_data;
            sel_q <= gnt_idx;
            ptr_q <= next_ptr(gnt_idx);
        end
    end

    assign bus.i_ready = gnt;
    assign bus.o       = o_q;
    assign bus.o_sel   = sel_q;
    assign bus.o_valid = (state_q == FULL);
    assign dbg_state   = state_q;
    assign dbg_ptr     = ptr_q;

endmodule

// File: tb/tb_mux_4to1_rr.sv
// Bench for mux_4to1_rr: directed scenarios plus random traffic against a reference model.
module tb_mux_4to1_rr;
    import mux_pkg::*;

    localparam int W  = 2;
    localparam int QW = W + 2;

    logic       clk;
    logic       rst_n;
    state_t     dbg_state;
    logic [1:0] dbg_ptr;

    mux_4to1_rr_if #(.width(W)) bus();

    mux_4to1_rr #(.width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state.
    bit           m_full;
    logic [W-1:0] m_o;
    logic [1:0]   m_sel;
    int           m_ptr;

    // Per-cycle observations taken before the edge.
    logic [3:0]   seen_rdy;
    logic [3:0]   exp_rdy;
    logic         pre_valid;
    logic [W-1:0] pre_o;
    logic [1:0]   pre_sel;

    logic [QW-1:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_grant(int p, logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_o    = '0;
        m_sel  = '0;
        m_ptr  = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic [3:0] iv, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3, input logic ordy);
        logic [W-1:0] d[4];
        int g;
        bit ld;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        @(negedge clk);
        bus.i_valid = iv;
        bus.i0 = d0; bus.i1 = d1; bus.i2 = d2; bus.i3 = d3;
        bus.o_ready = ordy;
        #1;
        seen_rdy  = bus.i_ready;
        pre_valid = bus.o_valid;
        pre_o     = bus.o;
        pre_sel   = bus.o_sel;
        ld = !m_full || ordy;
        g  = ld ? model_grant(m_ptr, iv) : -1;
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        if (ld) begin
            if (g >= 0) begin
                m_o    = d[g];
                m_sel  = 2'(g);
                m_full = 1'b1;
                m_ptr  = (g + 1) % 4;
                exp_q.push_back({2'(g), d[g]});
            end else begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_valid = '0;
        bus.o_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        bus.i_valid = 4'b1111;
        bus.i0 = 2'd1; bus.i1 = 2'd2; bus.i2 = 2'd3; bus.i3 = 2'd1;
        bus.o_ready = 1'b1;
        #2;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL por_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.i_ready !== 4'b0000) begin errors++; $display("FAIL por_ready: got %b expected 0000", bus.i_ready); end
        checks++; if (bus.o !== 2'b00 || bus.o_sel !== 2'b00) begin errors++; $display("FAIL por_data: got o=%b sel=%b expected 00/00", bus.o, bus.o_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(4'b0001, 2'd3, 2'd0, 2'd0, 2'd0, 1'b1);
        checks++; if (bus.o_valid !== 1'b1 || bus.o !== 2'd3) begin errors++; $display("FAIL pre_reset_word: got v=%b o=%b expected 1/11", bus.o_valid, bus.o); end
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_valid = 4'b1111;
        bus.o_ready = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o !== 2'b00 || bus.o_sel !== 2'b00) begin errors++; $display("FAIL mid_reset_data: got o=%b sel=%b expected 00/00", bus.o, bus.o_sel); end
        checks++; if (bus.i_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready: got %b expected 0000", bus.i_ready); end
        @(negedge clk);
        bus.i_valid = 4'b0000;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (bus.o_valid !== 1'b0 || dbg_state !== EMPTY) begin errors++; $display("FAIL post_reset_empty: got v=%b st=%b expected 0/EMPTY", bus.o_valid, dbg_state); end
    endtask

    task automatic test_single();
        do_reset();
        drive(4'b0100, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1);
        checks++; if (seen_rdy !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", seen_rdy); end
        checks++; if (bus.o !== 2'b10 || bus.o_sel !== 2'b10 || bus.o_valid !== 1'b1) begin errors++; $display("FAIL single_out: got o=%b sel=%b v=%b expected 10/10/1", bus.o, bus.o_sel, bus.o_valid); end
        checks++; if (dbg_ptr !== 2'd3) begin errors++; $display("FAIL single_ptr: got %0d expected 3", dbg_ptr); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 1'b1);
            checks++; if (seen_rdy !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, seen_rdy, 4'(1 << (i % 4))); end
            checks++; if (bus.o_sel !== 2'(i % 4) || bus.o !== 2'(i % 4) || bus.o_valid !== 1'b1) begin errors++; $display("FAIL rr_out[%0d]: got sel=%b o=%b v=%b expected %0d", i, bus.o_sel, bus.o, bus.o_valid, i % 4); end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        drive(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 1'b1);
        drive(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 1'b1);
        checks++; if (bus.o_sel !== 2'b01) begin errors++; $display("FAIL bp_setup: got sel=%b expected 01", bus.o_sel); end
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0);
            checks++; if (seen_rdy !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, seen_rdy); end
            checks++; if (bus.o_sel !== 2'b01 || bus.o !== 2'b01 || bus.o_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got sel=%b o=%b v=%b expected 01/01/1", i, bus.o_sel, bus.o, bus.o_valid); end
            checks++; if (dbg_ptr !== 2'd2) begin errors++; $display("FAIL bp_ptr[%0d]: got %0d expected 2", i, dbg_ptr); end
        end
        drive(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 1'b1);
        checks++; if (seen_rdy !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b expected 0100", seen_rdy); end
        checks++; if (bus.o_sel !== 2'b10) begin errors++; $display("FAIL bp_release_sel: got %b expected 10", bus.o_sel); end
    endtask

    task automatic test_drain();
        drive(4'b0000, 2'd3, 2'd3, 2'd3, 2'd3, 1'b1);
        checks++; if (seen_rdy !== 4'b0000) begin errors++; $display("FAIL drain_ready: got %b expected 0000", seen_rdy); end
        checks++; if (bus.o_valid !== 1'b0 || dbg_state !== EMPTY) begin errors++; $display("FAIL drain_valid: got v=%b st=%b expected 0/EMPTY", bus.o_valid, dbg_state); end
        checks++; if (bus.o !== 2'b10 || bus.o_sel !== 2'b10) begin errors++; $display("FAIL drain_hold: got o=%b sel=%b expected 10/10", bus.o, bus.o_sel); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(4'b0100, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
        drive(4'b0011, 2'd1, 2'd2, 2'd0, 2'd0, 1'b1);
        checks++; if (seen_rdy !== 4'b0001) begin errors++; $display("FAIL wrap_ready0: got %b expected 0001", seen_rdy); end
        checks++; if (bus.o_sel !== 2'd0 || bus.o !== 2'd1 || dbg_ptr !== 2'd1) begin errors++; $display("FAIL wrap_out0: got sel=%b o=%b ptr=%0d expected 00/01/1", bus.o_sel, bus.o, dbg_ptr); end
        drive(4'b0011, 2'd1, 2'd2, 2'd0, 2'd0, 1'b1);
        checks++; if (seen_rdy !== 4'b0010) begin errors++; $display("FAIL wrap_ready1: got %b expected 0010", seen_rdy); end
        checks++; if (bus.o_sel !== 2'd1 || bus.o !== 2'd2) begin errors++; $display("FAIL wrap_out1: got sel=%b o=%b expected 01/10", bus.o_sel, bus.o); end
    endtask

    task automatic test_random();
        logic [QW-1:0] front;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                  ($urandom_range(0, 3) != 0));
            checks++; if (seen_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, seen_rdy, exp_rdy); end
            checks++; if (bus.o_valid !== m_full || dbg_state !== state_t'(m_full)) begin errors++; $display("FAIL rnd_valid[%0d]: got v=%b st=%b expected %b", i, bus.o_valid, dbg_state, m_full); end
            checks++; if (bus.o !== m_o || bus.o_sel !== m_sel) begin errors++; $display("FAIL rnd_out[%0d]: got o=%b sel=%b expected %b/%b", i, bus.o, bus.o_sel, m_o, m_sel); end
            checks++; if (dbg_ptr !== 2'(m_ptr)) begin errors++; $display("FAIL rnd_ptr[%0d]: got %0d expected %0d", i, dbg_ptr, m_ptr); end
            if (pre_valid && bus.o_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_sb[%0d]: got word sel=%b o=%b expected none", i, pre_sel, pre_o);
                end else begin
                    front = exp_q.pop_front();
                    if ({pre_sel, pre_o} !== front) begin errors++; $display("FAIL rnd_sb[%0d]: got %b expected %b", i, {pre_sel, pre_o}, front); end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus.i_valid = '0;
        bus.i0 = '0; bus.i1 = '0; bus.i2 = '0; bus.i3 = '0;
        bus.o_ready = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_drain();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
